// File: rtl/alu_muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// Control encoding follows RV32M funct3.
package alu_muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_control_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } muldiv_state_t;

endpackage

// File: rtl/adder_n.sv
// Generic N-bit adder with carry-in.
// Used for the two's-complement negations in the muldiv unit.
module adder_n #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  assign sum = a + b + {{(W-1){1'b0}}, cin};

endmodule

// File: rtl/alu_muldiv_step.sv
// One iteration of shift-add multiply or restoring divide.
// acc holds {hi, lo}: product/multiplier or remainder/quotient.
module muldiv_step #(
  parameter int N = 32
) (
  input  logic [2*N-1:0] acc,
  input  logic [N-1:0]   operand,
  input  logic           is_div,
  output logic [2*N-1:0] acc_nxt
);

  logic [N:0] sum;
  logic [N:0] trial;

  always_comb begin
    sum   = {1'b0, acc[2*N-1:N]}
          + (acc[0] ? {1'b0, operand} : '0);
    trial = acc[2*N-1:N-1] - {1'b0, operand};
    if (is_div) begin
      // negative trial keeps the shifted remainder, quotient bit 0
      if (trial[N])
        acc_nxt = {acc[2*N-2:0], 1'b0};
      else
        acc_nxt = {trial[N-1:0], acc[N-2:0], 1'b1};
    end else begin
      acc_nxt = {sum, acc[N-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Multi-cycle RV32M multiply/divide unit, one bit per cycle.
// Magnitudes are iterated; signs are applied once at the end.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter  int N  = 32,
  localparam int CW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  input  muldiv_control_t control,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [N-1:0]    result,
  output logic            zero,
  output logic            div_by_zero,
  output logic            overflow
);

  muldiv_state_t   state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  muldiv_control_t ctrl_q, ctrl_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [N-1:0]    opd_q, opd_d;
  logic            neg_q, neg_d;
  logic            dbz_p_q, dbz_p_d;
  logic            ovf_p_q, ovf_p_d;
  logic [N-1:0]    result_q, result_d;
  logic            zero_q, zero_d;
  logic            dbz_q, dbz_d;
  logic            ovf_q, ovf_d;
  logic            o_valid_q, o_valid_d;

  logic           is_div_in;
  logic           sa, sb;
  logic           a_min, b_m1;
  logic [N-1:0]   neg_a, neg_b;
  logic [N-1:0]   abs_a, abs_b;
  logic [2*N-1:0] step_acc;
  logic [2*N-1:0] fin_in, fin_neg, fin;
  logic [N-1:0]   res_fin;

  assign is_div_in = control[2];
  assign sa = a[N-1] & (control == MULH || control == MULHSU
                     || control == DIV || control == REM);
  assign sb = b[N-1] & (control == MULH || control == DIV
                     || control == REM);
  assign a_min = (a == {1'b1, {(N-1){1'b0}}});
  assign b_m1  = (b == {N{1'b1}});

  adder_n #(.W(N)) u_neg_a (
    .a   (~a),
    .b   ('0),
    .cin (1'b1),
    .sum (neg_a)
  );

  adder_n #(.W(N)) u_neg_b (
    .a   (~b),
    .b   ('0),
    .cin (1'b1),
    .sum (neg_b)
  );

  assign abs_a = sa ? neg_a : a;
  assign abs_b = sb ? neg_b : b;

  muldiv_step #(.N(N)) u_step (
    .acc     (acc_q),
    .operand (opd_q),
    .is_div  (ctrl_q[2]),
    .acc_nxt (step_acc)
  );

  // quotient and remainder are negated in a zero-extended 2N field
  always_comb begin
    fin_in = step_acc;
    if (ctrl_q[2])
      fin_in = ctrl_q[1] ? {{N{1'b0}}, step_acc[2*N-1:N]}
                         : {{N{1'b0}}, step_acc[N-1:0]};
  end

  adder_n #(.W(2*N)) u_neg_r (
    .a   (~fin_in),
    .b   ('0),
    .cin (1'b1),
    .sum (fin_neg)
  );

  assign fin = neg_q ? fin_neg : fin_in;

  always_comb begin
    res_fin = '0;
    unique case (ctrl_q)
      MUL:                 res_fin = step_acc[N-1:0];
      MULH, MULHSU, MULHU: res_fin = fin[2*N-1:N];
      DIV, DIVU:           res_fin = dbz_p_q ? '1 : fin[N-1:0];
      REM, REMU:           res_fin = fin[N-1:0];
      default:             res_fin = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    acc_d     = acc_q;
    opd_d     = opd_q;
    neg_d     = neg_q;
    dbz_p_d   = dbz_p_q;
    ovf_p_d   = ovf_p_q;
    result_d  = result_q;
    zero_d    = zero_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    o_valid_d = o_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          state_d = S_BUSY;
          cnt_d   = '0;
          ctrl_d  = control;
          acc_d   = {{N{1'b0}}, is_div_in ? abs_a : abs_b};
          opd_d   = is_div_in ? abs_b : abs_a;
          neg_d   = (control == MULHSU || control == REM)
                  ? sa : (sa ^ sb);
          dbz_p_d = is_div_in & (b == '0);
          ovf_p_d = (control == DIV || control == REM)
                  & a_min & b_m1;
        end
      end
      S_BUSY: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N-1)) begin
          state_d   = S_DONE;
          result_d  = res_fin;
          zero_d    = (res_fin == '0);
          dbz_d     = dbz_p_q;
          ovf_d     = ovf_p_q;
          o_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (o_ready) begin
          state_d   = S_IDLE;
          o_valid_d = 1'b0;
          dbz_d     = 1'b0;
          ovf_d     = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ctrl_q    <= MUL;
      acc_q     <= '0;
      opd_q     <= '0;
      neg_q     <= 1'b0;
      dbz_p_q   <= 1'b0;
      ovf_p_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      acc_q     <= acc_d;
      opd_q     <= opd_d;
      neg_q     <= neg_d;
      dbz_p_q   <= dbz_p_d;
      ovf_p_q   <= ovf_p_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign i_ready     = (state_q == S_IDLE);
  assign o_valid     = o_valid_q;
  assign result      = result_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: arithmetic reference model plus
// directed vectors with hand-computed results.
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  localparam int N = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_valid = 1'b0;
  logic            o_ready = 1'b1;
  logic [N-1:0]    a = '0;
  logic [N-1:0]    b = '0;
  muldiv_control_t control = MUL;
  logic            i_ready;
  logic            o_valid;
  logic [N-1:0]    result;
  logic            zero;
  logic            div_by_zero;
  logic            overflow;

  alu_muldiv #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .a           (a),
    .b           (b),
    .control     (control),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .result      (result),
    .zero        (zero),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  typedef struct {
    logic [N-1:0] res;
    logic         dbz;
    logic         ovf;
  } exp_t;

  function automatic exp_t model(muldiv_control_t c,
                                 logic [N-1:0] x, logic [N-1:0] y);
    exp_t e;
    longint sx, sy, t;
    longint unsigned ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    e.res = '0; e.dbz = 1'b0; e.ovf = 1'b0;
    p = '0; t = 0;
    case (c)
      MUL:    begin p = sx * sy; e.res = p[31:0]; end
      MULH:   begin p = sx * sy; e.res = p[63:32]; end
      MULHSU: begin p = sx * longint'(uy); e.res = p[63:32]; end
      MULHU:  begin p = ux * uy; e.res = p[63:32]; end
      DIV: begin
        if (y == 0) begin e.res = '1; e.dbz = 1'b1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          e.res = x; e.ovf = 1'b1;
        end else begin t = sx / sy; e.res = t[31:0]; end
      end
      DIVU: begin
        if (y == 0) begin e.res = '1; e.dbz = 1'b1; end
        else begin p = ux / uy; e.res = p[31:0]; end
      end
      REM: begin
        if (y == 0) begin e.res = x; e.dbz = 1'b1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          e.res = '0; e.ovf = 1'b1;
        end else begin t = sx % sy; e.res = t[31:0]; end
      end
      REMU: begin
        if (y == 0) begin e.res = x; e.dbz = 1'b1; end
        else begin p = ux % uy; e.res = p[31:0]; end
      end
      default: e.res = '0;
    endcase
    return e;
  endfunction

  exp_t q[$];
  int   acc_edge = 0;

  // every cycle: handshake state and, while valid, the result
  initial begin
    exp_t e;
    bit   ev;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
      end else begin
        chk("m_i_ready", i_ready, q.size() == 0);
        ev = (q.size() > 0) && ((cyc - acc_edge) >= N);
        chk("m_o_valid", o_valid, ev);
        if (o_valid && q.size() > 0) begin
          e = q[0];
          chk("m_result", result, e.res);
          chk("m_zero", zero, e.res == '0);
          chk("m_dbz", div_by_zero, e.dbz);
          chk("m_ovf", overflow, e.ovf);
          if (o_ready) void'(q.pop_front());
        end
        if (i_valid && i_ready) begin
          q.push_back(model(control, a, b));
          acc_edge = cyc + 1;
        end
      end
    end
  end

  task automatic op(string nm, muldiv_control_t c,
                    logic [N-1:0] x, logic [N-1:0] y,
                    logic [N-1:0] er, logic ed, logic eo,
                    int hold, bit pulse);
    int t;
    int acc;
    o_ready = (hold == 0);
    control = c; a = x; b = y; i_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    i_valid = 1'b0;
    if (pulse) begin
      repeat (5) begin @(posedge clk); #1; end
      control = MUL; a = 32'd5; b = 32'd6; i_valid = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      i_valid = 1'b0;
    end
    t = 0;
    do begin @(negedge clk); t++; end while (!o_valid && t < 100);
    if (!o_valid) begin
      chk({nm, "_timeout"}, 0, 1);
      o_ready = 1'b1;
      @(posedge clk); #1;
      return;
    end
    chk({nm, "_lat"}, cyc - acc, N);
    chk(nm, result, er);
    chk({nm, "_zero"}, zero, er == '0);
    chk({nm, "_dbz"}, div_by_zero, ed);
    chk({nm, "_ovf"}, overflow, eo);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold"}, result, er);
      chk({nm, "_hold_rdy"}, i_ready, 0);
      chk({nm, "_hold_vld"}, o_valid, 1);
    end
    @(posedge clk); #1;
    if (hold > 0) begin
      o_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_i_ready", i_ready, 1);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_flags", {div_by_zero, overflow}, 0);
    @(posedge clk); #1;

    op("mul", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 0, 0, 0);
    op("mulh", MULH, 32'h8000_0000, 32'h8000_0000,
       32'h4000_0000, 0, 0, 0, 0);
    op("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
       32'hFFFF_FFFE, 0, 0, 0, 0);
    op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2,
       32'hFFFF_FFFF, 0, 0, 0, 0);
    op("div", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 0, 0, 0);
    op("rem", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 0, 0, 0);
    op("divu_pulse", DIVU, 32'hFFFF_FFFF, 32'd2,
       32'h7FFF_FFFF, 0, 0, 0, 1);
    op("remu", REMU, 32'd10, 32'd10, 32'd0, 0, 0, 0, 0);
    op("div0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 0, 0);
    op("remu0", REMU, 32'd5, 32'd0, 32'd5, 1, 0, 0, 0);
    op("rem0_neg", REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, 0, 0, 0);
    op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
       32'h8000_0000, 0, 1, 0, 0);
    op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF,
       32'd0, 0, 1, 0, 0);
    op("mulhu_hold", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
       32'hFFFF_FFFE, 0, 0, 5, 0);
    chk("flags_clr", {div_by_zero, overflow}, 0);

    control = MULHU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_i_ready", i_ready, 1);
    chk("midrst_o_valid", o_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_zero", zero, 1);
    @(posedge clk); #1;
    op("mul_after_rst", MUL, 32'd3, 32'd4, 32'd12, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
